abs_sample_tracker: RTL
=======================

Name: abs_sample_tracker

Overview:
- Stage directly upstream of threshold_integrator. Accepts a time-multiplexed stream of 16-bit per-channel samples from the DAC/ADC sample core.
- Converts each sample to a saturated 15-bit magnitude and holds the latest magnitude per channel, driving the integrator's 120-bit abs_sample_concat bus.
- Tracks channel freshness: flags when all 8 channels have been seen, and latches an error if any channel stops updating.

Parameters:
- OFFSET_BINARY, 1, 1 = sample_data is offset binary (0x8000 = zero); 0 = two's complement.
- STALE_W, 24, width of the per-channel staleness counters and of the stale_limit port.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- enable  in  1  run enable; low returns block to IDLE
- sample_valid  in  1  one sample presented this cycle
- sample_ch  in  3  channel index of presented sample
- sample_data  in  16  raw sample (format per OFFSET_BINARY)
- stale_limit  in  STALE_W  max cycles between updates of any channel; 0 disables watchdog
- abs_sample_concat  out  120  channel i magnitude at bits [(i+1)*15-1 -: 15]
- all_seen  out  1  every channel updated at least once since entering FILL
- err_stale  out  1  latched staleness error
- stale_ch  out  3  lowest-index channel that tripped err_stale
- sat_flag  out  1  sticky: some sample saturated (-32768 -> 32767)

Behaviour:
- Clock and reset: one clock, clk. resetn is synchronous and active-low. Reset clears all outputs, slots, counters and seen bits to 0, and sets the state to IDLE. Reset mid-operation takes effect on the next edge regardless of state.
- State IDLE: outputs held at 0, seen mask cleared, counters held at 0. enable=1 -> FILL.
- State FILL: samples accepted. When the seen mask reaches 8'hFF, go to RUN and set all_seen=1 on the same edge.
- State RUN: samples accepted; watchdog active when stale_limit != 0.
- State STALE_ERR: err_stale=1, stale_ch valid, slots frozen, sample_valid ignored. Left only by reset or by enable=0 -> IDLE. err_stale and stale_ch are cleared only by reset.
- enable=0 in any state other than STALE_ERR -> IDLE on the next edge; slots, all_seen and sat_flag are cleared.
- Pipeline:
  - Stage 1 registers valid, ch and signed value (offset binary: data ^ 16'h8000).
  - Stage 2 computes magnitude:
    - v >= 0 -> v[14:0]
    - v < 0 and v != -32768 -> (-v)[14:0]
    - v = -32768 -> 15'h7FFF and set sat_flag
  - Stage 2 writes the magnitude into slot[ch] and sets seen[ch].
  - Latency: sample_valid at cycle N -> abs_sample_concat updated and visible at cycle N+2. Back-to-back valid every cycle is supported. The same channel twice in a row gives last-write-wins.
- Samples arriving in IDLE are dropped. Pipeline stages in flight when enable falls are discarded.
- Watchdog (RUN only):
  - Per-channel counter increments each cycle and saturates at all-ones.
  - Counter clears on the stage-2 write for that channel.
  - When any counter reaches stale_limit -> STALE_ERR; stale_ch = lowest such index.
  - A write to a channel on the same edge its counter would reach the limit wins: no error for that channel.
  - Counters restart from 0 on FILL->RUN.
- Widths: all arithmetic on 17-bit signed to avoid negation overflow. Counter compare is an unsigned equality on STALE_W bits.

Decomposition:
- Shared package abs_tracker_pkg:
  - NUM_CH=8, SAMPLE_W=16, ABS_W=15, CONCAT_W=120
  - state localparams IDLE=2'd0, FILL=2'd1, RUN=2'd2, STALE_ERR=2'd3
  - the 15-bit saturation constant
- Natural sub-module: abs_sat_16to15, the combinational magnitude/saturation function with its saturation indicator. It is instantiated once in stage 2.

Test Plan:
- Offset binary, enable=1, samples ch0=0x8000, ch1=0xFFFF, ch2=0x0001, ch3=0x0000 at consecutive cycles -> two cycles after each valid, slot0=0, slot1=0x7FFF, slot2=0x7FFF (from -32767), slot3=0x7FFF with sat_flag=1.
- OFFSET_BINARY=0, sample ch5=16'hFF9C (-100) -> slot5=100 two cycles later; other slots unchanged.
- Write ch0..ch6 only -> all_seen stays 0, state FILL. Then write ch7 -> all_seen=1 at the edge of the ch7 stage-2 write.
- RUN, stale_limit=50, refresh ch0..ch6 every 10 cycles, never ch7 -> err_stale=1, stale_ch=7 exactly 50 cycles after RUN entry. Further samples are ignored.
- stale_limit=20, ch3 written on the cycle its counter reaches 20 -> no error. stale_limit=0 with no traffic for 10000 cycles -> err_stale stays 0.
- resetn=0 for one cycle mid-stream with valid asserted -> next cycle all outputs are 0 and the state is IDLE. enable=0 mid-RUN -> IDLE, concat=0, err_stale unaffected.

Source files
------------

// File: rtl/abs_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Package     : abs_tracker_pkg
// Description : Shared widths, state encoding and helpers for the
//               abs_sample_tracker magnitude/freshness stage.
// Revision    : 1.0 - initial release
// ============================================================================
package abs_tracker_pkg;

    localparam int NUM_CH   = 8;
    localparam int CH_W     = 3;
    localparam int SAMPLE_W = 16;
    localparam int ABS_W    = 15;
    localparam int CONCAT_W = NUM_CH * ABS_W;

    // Largest representable magnitude; -32768 is clamped to this.
    localparam logic [ABS_W-1:0]    ABS_SAT     = 15'h7FFF;
    // XOR mask turning offset binary into two's complement.
    localparam logic [SAMPLE_W-1:0] OFFSET_FLIP = 16'h8000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        RUN       = 2'd2,
        STALE_ERR = 2'd3
    } tracker_state_t;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [CH_W-1:0] lowest_index(input logic [NUM_CH-1:0] mask);
        lowest_index = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) lowest_index = CH_W'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_sat_16to15.sv
`default_nettype none
// ============================================================================
// Module      : abs_sat_16to15
// Description : Combinational 16-bit signed to 15-bit magnitude conversion.
//               The single unrepresentable input (-32768) clamps to 0x7FFF
//               and raises the saturation indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module abs_sat_16to15
    import abs_tracker_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] value,
    output logic        [ABS_W-1:0]    magnitude,
    output logic                       saturated
);

    // Work one bit wider so negating the most negative value cannot wrap.
    logic signed [SAMPLE_W:0] w_ext;
    logic signed [SAMPLE_W:0] w_neg;
    logic                     w_most_neg;

    assign w_ext      = {value[SAMPLE_W-1], value};
    assign w_neg      = -w_ext;
    assign w_most_neg = w_ext[SAMPLE_W] && (w_ext[ABS_W-1:0] == '0);

    // Select magnitude: pass-through, negated, or clamped.
    always_comb begin
        magnitude = w_ext[ABS_W-1:0];
        saturated = 1'b0;
        if (w_most_neg) begin
            magnitude = ABS_SAT;
            saturated = 1'b1;
        end else if (w_ext[SAMPLE_W]) begin
            magnitude = w_neg[ABS_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/abs_sample_tracker.sv
`default_nettype none
// ============================================================================
// Module      : abs_sample_tracker
// Description : Converts a time-multiplexed 8-channel sample stream into
//               per-channel saturated magnitudes, tracks that every channel
//               has been seen and watches for channels that stop updating.
// Revision    : 1.0 - initial release
// ============================================================================
module abs_sample_tracker
    import abs_tracker_pkg::*;
#(
    parameter bit OFFSET_BINARY = 1'b1,
    parameter int STALE_W       = 24
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [CH_W-1:0]     sample_ch,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [STALE_W-1:0]  stale_limit,
    output logic [CONCAT_W-1:0] abs_sample_concat,
    output logic                all_seen,
    output logic                err_stale,
    output logic [CH_W-1:0]     stale_ch,
    output logic                sat_flag
);

    tracker_state_t r_state;
    tracker_state_t w_state_next;

    // Stage 1
    logic                       r_s1_valid;
    logic [CH_W-1:0]            r_s1_ch;
    logic signed [SAMPLE_W-1:0] r_s1_value;

    // Stage 2 / storage
    logic [ABS_W-1:0]   w_mag;
    logic               w_sat;
    logic               w_accept;
    logic               w_write;
    logic [NUM_CH-1:0]  w_wr_onehot;
    logic [NUM_CH-1:0]  w_seen_next;
    logic [NUM_CH-1:0]  r_seen;
    logic [ABS_W-1:0]   r_slot [NUM_CH];
    logic               r_all_seen;
    logic               r_sat_flag;

    // Watchdog
    logic               w_watch;
    logic [STALE_W-1:0] r_cnt     [NUM_CH];
    logic [STALE_W-1:0] w_cnt_inc [NUM_CH];
    logic [NUM_CH-1:0]  w_trip;
    logic               r_err_stale;
    logic [CH_W-1:0]    r_stale_ch;

    // Samples are only taken while actively filling or running; dropping
    // enable also kills anything already in the pipeline.
    assign w_accept    = enable && ((r_state == FILL) || (r_state == RUN));
    assign w_write     = r_s1_valid && w_accept;
    assign w_wr_onehot = w_write ? (NUM_CH'(1) << r_s1_ch) : '0;
    assign w_seen_next = r_seen | w_wr_onehot;
    assign w_watch     = (r_state == RUN) && (stale_limit != '0);

    // Stage 1: capture sample and normalise to two's complement.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_value <= '0;
        end else begin
            r_s1_valid <= sample_valid && w_accept;
            r_s1_ch    <= sample_ch;
            r_s1_value <= OFFSET_BINARY ? (sample_data ^ OFFSET_FLIP) : sample_data;
        end
    end

    abs_sat_16to15 u_abs_sat (
        .value     (r_s1_value),
        .magnitude (w_mag),
        .saturated (w_sat)
    );

    // Per-channel counter increment and limit detection; a write on the
    // same edge beats the limit for that channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_inc[i] = (r_cnt[i] == '1) ? r_cnt[i] : r_cnt[i] + STALE_W'(1);
            w_trip[i]    = w_watch && !w_wr_onehot[i] && (w_cnt_inc[i] == stale_limit);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = FILL;
            end
            FILL: begin
                if (!enable)                 w_state_next = IDLE;
                else if (w_seen_next == '1)  w_state_next = RUN;
            end
            RUN: begin
                if (!enable)      w_state_next = IDLE;
                else if (|w_trip) w_state_next = STALE_ERR;
            end
            STALE_ERR: begin
                if (!enable) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Stage 2: slot storage, seen mask, all_seen and sticky saturation.
    always_ff @(posedge clk) begin
        if (!resetn || (w_state_next == IDLE)) begin
            for (int i = 0; i < NUM_CH; i++) r_slot[i] <= '0;
            r_seen     <= '0;
            r_all_seen <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_write) begin
                r_slot[r_s1_ch] <= w_mag;
                r_sat_flag      <= r_sat_flag | w_sat;
            end
            r_seen <= w_seen_next;
            if ((r_state == FILL) && (w_state_next == RUN)) r_all_seen <= 1'b1;
        end
    end

    // Staleness counters: run only in RUN, frozen in STALE_ERR, zero otherwise.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!resetn) begin
                r_cnt[i] <= '0;
            end else if ((r_state == RUN) && (w_state_next != IDLE)) begin
                r_cnt[i] <= w_wr_onehot[i] ? '0 : w_cnt_inc[i];
            end else if (w_state_next != STALE_ERR) begin
                r_cnt[i] <= '0;
            end
        end
    end

    // Error latch: survives enable drop, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_stale <= 1'b0;
            r_stale_ch  <= '0;
        end else if ((r_state == RUN) && (w_state_next == STALE_ERR)) begin
            r_err_stale <= 1'b1;
            r_stale_ch  <= lowest_index(w_trip);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_concat
        assign abs_sample_concat[(gi+1)*ABS_W-1 -: ABS_W] = r_slot[gi];
    end

    assign all_seen  = r_all_seen;
    assign err_stale = r_err_stale;
    assign stale_ch  = r_stale_ch;
    assign sat_flag  = r_sat_flag;

endmodule
`default_nettype wire
